wb_sum_mult_responder: RTL and testbench
========================================

WB_SUM_MULT_RESPONDER -- requirements
Module: wb_sum_mult_responder

Interface
REQ-001 Parameter: BASE_ADDR, 32'h3000_0000, Wishbone base address of the 16-byte register window.
REQ-002 Parameter: TIMEOUT, 16'hFFFF, maximum accelerator cycles from launch to busy-fall before abort.
REQ-003 wb_clk_i  input  1  sole clock; all logic on rising edge.
REQ-004 wb_rst_ni  input  1  synchronous, active-low reset.
REQ-005 wbs_cyc_i, wbs_stb_i, wbs_we_i  input  1 each  Wishbone classic cycle, strobe, write-enable.
REQ-006 wbs_adr_i  input  32  byte address; bits [3:2] select the register.
REQ-007 wbs_dat_i  input  32  write data.
REQ-008 wbs_sel_i  input  4  byte lane enables.
REQ-009 wbs_ack_o  output  1  transfer acknowledge.
REQ-010 wbs_dat_o  output  32  read data.
REQ-011 acc_start  output  1  one-cycle launch pulse to the sum/multiply accelerator.
REQ-012 acc_n  output  16  operand to the accelerator, held stable while the accelerator is running.
REQ-013 acc_busy  input  1  accelerator busy; high while computing.
REQ-014 acc_x  input  32  accelerator result; valid on the cycle acc_busy falls.
REQ-015 irq  output  1  level interrupt: done AND irq_en.

Function
REQ-016 Hit: cyc&stb with wbs_adr_i[31:4]==BASE_ADDR[31:4]. Non-hits are ignored and get no ack.
REQ-017 Ack: asserted for exactly one cycle, in the cycle after a hit is first sampled; deasserted the following cycle even if stb stays high. Each transfer takes 2 cycles; ack is never back-to-back.
REQ-018 Register map (offset): 0x0 CTRL, 0x4 N, 0x8 STATUS, 0xC RESULT. wbs_dat_o is valid with ack and is 0 when ack is low.
REQ-019 CTRL write: bit0 go (self-clearing, reads 0); bit1 irq_en (R/W); bit2 abort (self-clearing).
REQ-020 N write: bits[15:0] via sel[1:0] bytewise; upper bits read 0. A write while the FSM is not IDLE is dropped and sets err.
REQ-021 STATUS read: {28'b0, err, timeout, done, busy}. busy = FSM not IDLE. Writing 1 to bits 1..3 clears the matching flag (W1C). Writes to bit0 are ignored.
REQ-022 RESULT: read-only 32-bit register holding the last captured acc_x. Writes are ignored.
REQ-023 FSM states: IDLE, LAUNCH, ARM, RUN.
- IDLE -> LAUNCH on a go write; a go write in any other state sets err and is otherwise ignored.
- LAUNCH: acc_start=1 for one cycle; done and timeout are cleared; -> ARM.
- ARM: wait for acc_busy=1, then -> RUN.
- RUN: on acc_busy=0, RESULT<=acc_x, done<=1, -> IDLE.
REQ-024 Watchdog: a 16-bit counter is cleared in LAUNCH and increments each cycle in ARM and RUN. When it reaches TIMEOUT: timeout<=1, RESULT is unchanged, done stays 0, -> IDLE.
REQ-025 Abort write in ARM or RUN -> IDLE next cycle. RESULT and done are unchanged; no flag is set. Abort in IDLE has no effect.
REQ-026 Priority in one cycle: reset > abort > timeout > busy-fall capture. A W1C of done is overridden by a same-cycle done set (set wins).
REQ-027 acc_n is driven from the N register at all times. Because N writes are dropped outside IDLE, acc_n holds stable during a run.

Reset
REQ-028 With wb_rst_ni=0 at a clock edge, the block is cleared: FSM=IDLE; wbs_ack_o, wbs_dat_o, acc_start, irq=0; N, RESULT, irq_en, done, timeout, err, watchdog=0.
REQ-029 Reset mid-run: the FSM returns to IDLE and acc_x is not captured. A pending transfer gets no ack; the initiator re-issues it.
REQ-030 Outputs take their reset values on the first edge with wb_rst_ni low; normal operation starts on the first edge with it high.

Verification
REQ-031 Write N=0x0005; write CTRL=0x3; model holds busy 10 cycles then returns acc_x=0x0000_000F -> acc_start pulses once with acc_n=0x0005; STATUS reads 0x2; RESULT reads 0x0000_000F; irq=1.
REQ-032 Single read of STATUS with stb held high 4 cycles -> exactly one ack, in cycle 2, with dat=0x0; no second ack.
REQ-033 go while RUN, then write N=0x1234 -> no second acc_start; acc_n unchanged; STATUS bit3 (err)=1; writing STATUS=0x8 clears it.
REQ-034 TIMEOUT=16, model never asserts busy -> after 16 cycles in ARM, STATUS reads 0x4; RESULT keeps its old value; irq=0.
REQ-035 Write N with sel=4'b0010, dat=0xAB00 over N=0x0005 -> N reads 0x0000_AB05.
REQ-036 wb_rst_ni low during RUN for one edge -> every output 0, STATUS=0x0; a later busy-fall with acc_x=0xDEAD_BEEF leaves RESULT=0.

Source files
------------

// File: rtl/wb_sum_mult_responder_if.sv
// Wishbone classic slave bundle for the sum/multiply responder; one ack per strobe,
// one cycle after the hit. The initiator must drop stb between transfers.
interface wb_sum_mult_responder_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic [3:0]  wbs_sel_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i, wbs_sel_i,
    output wbs_ack_o, wbs_dat_o
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i, wbs_sel_i,
    input  wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/wb_sum_mult_responder.sv
// Wishbone register front-end that launches a sum/multiply accelerator and captures its result.
// Ack one cycle after a hit, once per strobe; the accelerator run is guarded by a watchdog.
module wb_sum_mult_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter logic [15:0] TIMEOUT   = 16'hFFFF
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_ni,
  wb_sum_mult_responder_if.slave        wbs,
  output logic                          acc_start,
  output logic [15:0]                   acc_n,
  input  logic                          acc_busy,
  input  logic [31:0]                   acc_x,
  output logic                          irq
);
  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_ARM, S_RUN} state_e;

  state_e      state_q, state_d;
  logic        ack_q, ack_d, served_q, served_d;
  logic [31:0] dat_q, dat_d, result_q, result_d;
  logic [15:0] n_q, n_d, wdog_q, wdog_d, wdog_inc;
  logic        irq_en_q, irq_en_d, done_q, done_d, timeout_q, timeout_d, err_q, err_d;
  logic        start_q, start_d, irq_q, irq_d;
  logic        req, hit, wr, idle, ctrl_wr, n_wr, stat_wr, go, abort;
  logic [31:0] rd_dat;
  logic        unused_bits;

  assign req      = wbs.wbs_cyc_i & wbs.wbs_stb_i;
  // served_q holds off a second ack until the initiator drops the strobe
  assign hit      = req & ~served_q & (wbs.wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign wr       = hit & wbs.wbs_we_i;
  assign idle     = (state_q == S_IDLE);
  assign ctrl_wr  = wr & (wbs.wbs_adr_i[3:2] == 2'd0) & wbs.wbs_sel_i[0];
  assign n_wr     = wr & (wbs.wbs_adr_i[3:2] == 2'd1);
  assign stat_wr  = wr & (wbs.wbs_adr_i[3:2] == 2'd2) & wbs.wbs_sel_i[0];
  assign go       = ctrl_wr & wbs.wbs_dat_i[0];
  assign abort    = ctrl_wr & wbs.wbs_dat_i[2];
  assign wdog_inc = wdog_q + 16'd1;
  assign unused_bits = ^{wbs.wbs_adr_i[1:0], wbs.wbs_dat_i[31:16], wbs.wbs_sel_i[3:2]};

  always_comb begin
    rd_dat = '0;
    case (wbs.wbs_adr_i[3:2])
      2'd0:    rd_dat = {30'd0, irq_en_q, 1'b0};
      2'd1:    rd_dat = {16'd0, n_q};
      2'd2:    rd_dat = {28'd0, err_q, timeout_q, done_q, ~idle};
      default: rd_dat = result_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    served_d  = req & (served_q | hit);
    ack_d     = hit;
    dat_d     = (hit & ~wbs.wbs_we_i) ? rd_dat : 32'd0;
    result_d  = result_q;
    n_d       = n_q;
    wdog_d    = wdog_q;
    irq_en_d  = irq_en_q;
    done_d    = done_q;
    timeout_d = timeout_q;
    err_d     = err_q;
    start_d   = 1'b0;

    if (ctrl_wr) irq_en_d = wbs.wbs_dat_i[1];
    if (stat_wr) begin
      if (wbs.wbs_dat_i[1]) done_d    = 1'b0;
      if (wbs.wbs_dat_i[2]) timeout_d = 1'b0;
      if (wbs.wbs_dat_i[3]) err_d     = 1'b0;
    end
    if (n_wr) begin
      if (idle) begin
        if (wbs.wbs_sel_i[0]) n_d[7:0]  = wbs.wbs_dat_i[7:0];
        if (wbs.wbs_sel_i[1]) n_d[15:8] = wbs.wbs_dat_i[15:8];
      end else begin
        err_d = 1'b1;
      end
    end
    if (go && !idle) err_d = 1'b1;

    // Flag sets below come after the W1C clears so a same-cycle set wins
    case (state_q)
      S_IDLE: begin
        if (go) begin
          state_d = S_LAUNCH;
          start_d = 1'b1;
        end
      end
      S_LAUNCH: begin
        done_d    = 1'b0;
        timeout_d = 1'b0;
        wdog_d    = 16'd0;
        state_d   = S_ARM;
      end
      default: begin
        wdog_d = wdog_inc;
        if (abort) begin
          state_d = S_IDLE;
        end else if (wdog_inc == TIMEOUT) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else if (state_q == S_ARM) begin
          if (acc_busy) state_d = S_RUN;
        end else if (!acc_busy) begin
          result_d = acc_x;
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end
      end
    endcase

    irq_d = done_d & irq_en_d;
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state_q   <= S_IDLE;
      ack_q     <= 1'b0;
      served_q  <= 1'b0;
      dat_q     <= '0;
      result_q  <= '0;
      n_q       <= '0;
      wdog_q    <= '0;
      irq_en_q  <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      err_q     <= 1'b0;
      start_q   <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ack_q     <= ack_d;
      served_q  <= served_d;
      dat_q     <= dat_d;
      result_q  <= result_d;
      n_q       <= n_d;
      wdog_q    <= wdog_d;
      irq_en_q  <= irq_en_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      err_q     <= err_d;
      start_q   <= start_d;
      irq_q     <= irq_d;
    end
  end

  assign wbs.wbs_ack_o = ack_q;
  assign wbs.wbs_dat_o = dat_q;
  assign acc_start     = start_q;
  assign acc_n         = n_q;
  assign irq           = irq_q;
endmodule

// File: tb/tb_wb_sum_mult_responder.sv
// Bench for wb_sum_mult_responder: register table, directed run/abort/timeout/reset
// sequences, and randomized register traffic checked against a register-level model.
module tb_wb_sum_mult_responder;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        acc_start;
  logic [15:0] acc_n;
  logic        acc_busy = 1'b0;
  logic [31:0] acc_x = 32'd0;
  logic        irq;

  wb_sum_mult_responder_if bus();

  wb_sum_mult_responder #(.BASE_ADDR(BASE), .TIMEOUT(16'd16)) dut (
    .wb_clk_i (clk),
    .wb_rst_ni(rst_n),
    .wbs      (bus),
    .acc_start(acc_start),
    .acc_n    (acc_n),
    .acc_busy (acc_busy),
    .acc_x    (acc_x),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  // Accelerator model: busy for busy_len cycles after a start pulse, result presented as busy falls
  int          busy_len = 4;
  bit          never_busy = 1'b0;
  logic [31:0] next_x = 32'd0;
  int          busy_cnt = 0;
  int          start_cnt = 0;
  logic [15:0] start_n = 16'd0;

  always @(negedge clk) begin
    if (acc_start) begin
      start_cnt++;
      start_n = acc_n;
      if (!never_busy) begin
        acc_busy = 1'b1;
        busy_cnt = busy_len;
      end
    end else if (acc_busy) begin
      busy_cnt--;
      if (busy_cnt == 0) begin
        acc_busy = 1'b0;
        acc_x    = next_x;
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] d,
                      input logic [3:0] sel, output logic [31:0] rd, output logic ok);
    ok = 1'b0;
    rd = 32'd0;
    @(posedge clk); #1;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = we;
    bus.wbs_adr_i = adr;
    bus.wbs_dat_i = d;
    bus.wbs_sel_i = sel;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (bus.wbs_ack_o) begin
        ok = 1'b1;
        rd = bus.wbs_dat_o;
        break;
      end
    end
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
  endtask

  task automatic wr(input string name, input logic [3:0] off, input logic [31:0] d, input logic [3:0] sel);
    logic [31:0] rd;
    logic        ok;
    xfer(1'b1, BASE + {28'd0, off}, d, sel, rd, ok);
    check({name, "_ack"}, {31'd0, ok}, 32'd1);
  endtask

  task automatic rd_chk(input string name, input logic [3:0] off, input logic [31:0] exp);
    logic [31:0] rd;
    logic        ok;
    xfer(1'b0, BASE + {28'd0, off}, 32'd0, 4'hF, rd, ok);
    check({name, "_ack"}, {31'd0, ok}, 32'd1);
    check(name, rd, exp);
  endtask

  typedef struct {
    logic        we;
    logic [3:0]  off;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic we, input logic [3:0] off, input logic [31:0] dat,
                              input logic [3:0] sel, input logic [31:0] exp, input string name);
    vec_t v;
    v.we = we; v.off = off; v.dat = dat; v.sel = sel; v.exp = exp; v.name = name;
    return v;
  endfunction

  // Register-level reference state
  logic [15:0] m_n;
  logic [31:0] m_result;
  logic        m_irq_en, m_done, m_to, m_err;

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not complete, want completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, d, s;
    logic        ok;
    int          s0, ack_cnt, first, op, len;
    logic [31:0] d0;

    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
    bus.wbs_adr_i = 32'd0; bus.wbs_dat_i = 32'd0; bus.wbs_sel_i = 4'd0;

    repeat (2) @(negedge clk);
    check("reset_ack",   {31'd0, bus.wbs_ack_o}, 32'd0);
    check("reset_dat",   bus.wbs_dat_o, 32'd0);
    check("reset_start", {31'd0, acc_start}, 32'd0);
    check("reset_acc_n", {16'd0, acc_n}, 32'd0);
    check("reset_irq",   {31'd0, irq}, 32'd0);
    rst_n = 1'b1;

    tbl.push_back(mk(1'b0, 4'h8, 32'h0,         4'hF, 32'h0,    "rst_status"));
    tbl.push_back(mk(1'b0, 4'h0, 32'h0,         4'hF, 32'h0,    "rst_ctrl"));
    tbl.push_back(mk(1'b0, 4'h4, 32'h0,         4'hF, 32'h0,    "rst_nreg"));
    tbl.push_back(mk(1'b0, 4'hC, 32'h0,         4'hF, 32'h0,    "rst_result"));
    tbl.push_back(mk(1'b1, 4'h4, 32'h0005,      4'hF, 32'h0,    "n_wr"));
    tbl.push_back(mk(1'b0, 4'h4, 32'h0,         4'hF, 32'h0005, "n_rd"));
    tbl.push_back(mk(1'b1, 4'h4, 32'hAB00,      4'b0010, 32'h0, "n_byte1_wr"));
    tbl.push_back(mk(1'b0, 4'h4, 32'h0,         4'hF, 32'hAB05, "n_byte1_rd"));
    tbl.push_back(mk(1'b1, 4'h4, 32'h1234_5677, 4'b0001, 32'h0, "n_byte0_wr"));
    tbl.push_back(mk(1'b0, 4'h4, 32'h0,         4'hF, 32'hAB77, "n_byte0_rd"));
    tbl.push_back(mk(1'b1, 4'h4, 32'hFFFF_FFFF, 4'b1100, 32'h0, "n_upper_wr"));
    tbl.push_back(mk(1'b0, 4'h4, 32'h0,         4'hF, 32'hAB77, "n_upper_rd"));
    tbl.push_back(mk(1'b1, 4'hC, 32'h1234,      4'hF, 32'h0,    "result_wr"));
    tbl.push_back(mk(1'b0, 4'hC, 32'h0,         4'hF, 32'h0,    "result_ro"));
    tbl.push_back(mk(1'b1, 4'h8, 32'h1,         4'hF, 32'h0,    "status_b0_wr"));
    tbl.push_back(mk(1'b0, 4'h8, 32'h0,         4'hF, 32'h0,    "status_b0_rd"));
    tbl.push_back(mk(1'b1, 4'h0, 32'h2,         4'hF, 32'h0,    "ctrl_wr"));
    tbl.push_back(mk(1'b0, 4'h0, 32'h0,         4'hF, 32'h2,    "ctrl_rd"));
    tbl.push_back(mk(1'b1, 4'h0, 32'h0,         4'hF, 32'h0,    "ctrl_clr_wr"));
    tbl.push_back(mk(1'b0, 4'h0, 32'h0,         4'hF, 32'h0,    "ctrl_clr_rd"));
    tbl.push_back(mk(1'b1, 4'h4, 32'h0005,      4'hF, 32'h0,    "n5_wr"));
    tbl.push_back(mk(1'b0, 4'h4, 32'h0,         4'hF, 32'h0005, "n5_rd"));
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].we) wr(tbl[i].name, tbl[i].off, tbl[i].dat, tbl[i].sel);
      else           rd_chk(tbl[i].name, tbl[i].off, tbl[i].exp);
    end

    // Addresses outside the window are never acknowledged
    xfer(1'b0, BASE + 32'h10, 32'd0, 4'hF, rd, ok);
    check("nohit_above_ack", {31'd0, ok}, 32'd0);
    xfer(1'b1, 32'h2000_0004, 32'hFFFF, 4'hF, rd, ok);
    check("nohit_other_ack", {31'd0, ok}, 32'd0);
    rd_chk("nohit_n_unchanged", 4'h4, 32'h5);

    // Strobe held for four cycles: a single ack in the second cycle
    @(posedge clk); #1;
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b0;
    bus.wbs_adr_i = BASE + 32'h8; bus.wbs_sel_i = 4'hF;
    ack_cnt = 0; first = -1; d0 = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (bus.wbs_ack_o) begin
        ack_cnt++;
        if (first < 0) begin first = i; d0 = bus.wbs_dat_o; end
      end
    end
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
    check("hold_ack_count", ack_cnt, 32'd1);
    check("hold_ack_cycle", first, 32'd0);
    check("hold_ack_dat", d0, 32'd0);
    check("dat_zero_no_ack", bus.wbs_dat_o, 32'd0);

    // Normal run: N=5, busy 10 cycles, result 0xF, irq enabled
    busy_len = 10; next_x = 32'h0000_000F; s0 = start_cnt;
    wr("go1", 4'h0, 32'h3, 4'hF);
    repeat (20) @(posedge clk); #1;
    check("go1_starts", start_cnt - s0, 32'd1);
    check("go1_acc_n", {16'd0, start_n}, 32'h5);
    rd_chk("go1_status", 4'h8, 32'h2);
    rd_chk("go1_result", 4'hC, 32'h0000_000F);
    check("go1_irq", {31'd0, irq}, 32'd1);

    // go and N write while running are dropped and raise err
    busy_len = 12; next_x = 32'h0000_0111; s0 = start_cnt;
    wr("go2", 4'h0, 32'h3, 4'hF);
    wr("go2_again", 4'h0, 32'h3, 4'hF);
    wr("n_busy", 4'h4, 32'h1234, 4'hF);
    check("n_busy_acc_n", {16'd0, acc_n}, 32'h5);
    repeat (16) @(posedge clk); #1;
    check("go2_starts", start_cnt - s0, 32'd1);
    rd_chk("err_status", 4'h8, 32'hA);
    rd_chk("err_nreg", 4'h4, 32'h5);
    wr("err_clr", 4'h8, 32'h8, 4'hF);
    rd_chk("err_clr_rd", 4'h8, 32'h2);

    // Watchdog: busy never rises, 16 cycles in ARM then timeout
    never_busy = 1'b1; s0 = start_cnt;
    wr("go3", 4'h0, 32'h3, 4'hF);
    repeat (14) @(posedge clk);
    rd_chk("to_last_busy", 4'h8, 32'h1);
    rd_chk("to_status", 4'h8, 32'h4);
    rd_chk("to_result", 4'hC, 32'h0000_0111);
    check("to_irq", {31'd0, irq}, 32'd0);
    check("to_starts", start_cnt - s0, 32'd1);
    never_busy = 1'b0;

    // Abort during RUN: no capture, no flags
    busy_len = 12; next_x = 32'h0000_0222; s0 = start_cnt;
    wr("go4", 4'h0, 32'h3, 4'hF);
    repeat (3) @(posedge clk);
    wr("abort", 4'h0, 32'h6, 4'hF);
    rd_chk("abort_status", 4'h8, 32'h0);
    repeat (16) @(posedge clk);
    rd_chk("abort_result", 4'hC, 32'h0000_0111);
    rd_chk("abort_status2", 4'h8, 32'h0);
    check("abort_irq", {31'd0, irq}, 32'd0);

    // Randomized traffic against the register-level model
    wr("sync_n", 4'h4, 32'h0, 4'hF);
    wr("sync_ctrl", 4'h0, 32'h0, 4'hF);
    wr("sync_stat", 4'h8, 32'hE, 4'hF);
    m_n = 16'd0; m_irq_en = 1'b0; m_done = 1'b0; m_to = 1'b0; m_err = 1'b0; m_result = 32'h0000_0111;
    for (int it = 0; it < 60; it++) begin
      op = $urandom_range(0, 6);
      case (op)
        0: begin
          d = $urandom; s = $urandom_range(0, 15);
          wr("rnd_n_wr", 4'h4, d, s[3:0]);
          if (s[0]) m_n[7:0]  = d[7:0];
          if (s[1]) m_n[15:8] = d[15:8];
        end
        1: rd_chk("rnd_n_rd", 4'h4, {16'd0, m_n});
        2: begin
          d = $urandom & 32'h6;
          wr("rnd_ctrl_wr", 4'h0, d, 4'hF);
          m_irq_en = d[1];
          rd_chk("rnd_ctrl_rd", 4'h0, {30'd0, m_irq_en, 1'b0});
        end
        3: rd_chk("rnd_status_rd", 4'h8, {28'd0, m_err, m_to, m_done, 1'b0});
        4: rd_chk("rnd_result_rd", 4'hC, m_result);
        5: begin
          len = $urandom_range(2, 10);
          busy_len = len; next_x = $urandom; s0 = start_cnt;
          wr("rnd_go", 4'h0, {30'd0, m_irq_en, 1'b1}, 4'hF);
          repeat (len + 6) @(posedge clk); #1;
          m_result = next_x; m_done = 1'b1; m_to = 1'b0;
          check("rnd_starts", start_cnt - s0, 32'd1);
          check("rnd_acc_n", {16'd0, start_n}, {16'd0, m_n});
          rd_chk("rnd_run_status", 4'h8, {28'd0, m_err, m_to, m_done, 1'b0});
        end
        default: begin
          d = $urandom & 32'hF;
          wr("rnd_w1c", 4'h8, d, 4'hF);
          if (d[1]) m_done = 1'b0;
          if (d[2]) m_to   = 1'b0;
          if (d[3]) m_err  = 1'b0;
        end
      endcase
      check("rnd_irq", {31'd0, irq}, {31'd0, m_done & m_irq_en});
    end

    // Reset during RUN: outputs cleared, late busy-fall not captured
    wr("pre_rst_n", 4'h4, 32'h00C3, 4'hF);
    busy_len = 12; next_x = 32'hDEAD_BEEF;
    wr("go5", 4'h0, 32'h3, 4'hF);
    repeat (4) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    check("midrst_ack",   {31'd0, bus.wbs_ack_o}, 32'd0);
    check("midrst_dat",   bus.wbs_dat_o, 32'd0);
    check("midrst_start", {31'd0, acc_start}, 32'd0);
    check("midrst_acc_n", {16'd0, acc_n}, 32'd0);
    check("midrst_irq",   {31'd0, irq}, 32'd0);
    repeat (16) @(posedge clk);
    rd_chk("midrst_status", 4'h8, 32'h0);
    rd_chk("midrst_result", 4'hC, 32'h0);
    rd_chk("midrst_ctrl",   4'h0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
